// File: rtl/data_memory_be.sv
// Byte-enabled 32-bit data memory with a single-cycle load response and a post-reset clear sweep.
// Storage is split into four byte-lane slices so sub-word stores touch only their lanes.

module data_memory_be_lane #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);
    logic [7:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

module data_memory_be #(
    parameter int ADDR_WIDTH     = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] data_in,
    output logic        rsp_valid,
    output logic [31:0] data_out,
    output logic        err
);
    localparam int NUM_LANES = 4;

    typedef enum logic {CLEAR, READY} state_t;
    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0]             clr_cnt;
    logic [ADDR_WIDTH-1:0]             mem_addr;
    logic [NUM_LANES-1:0]              lane_we;
    logic [NUM_LANES-1:0][7:0]         lane_wdata;
    logic [NUM_LANES-1:0][7:0]         lane_rdata;
    logic [31:0]                       store_word;
    logic [31:0]                       load_ext;
    logic [7:0]                        ld_byte;
    logic [15:0]                       ld_half;
    logic                              accept, is_access, bad, do_store;

    assign req_ready = (state_q == READY);
    assign accept    = req_valid && req_ready;
    assign is_access = mem_read || mem_write;

    // Any of these rejects the request before it can touch the array.
    assign bad = (size == 2'b11)
              || (size == 2'b01 && addr[0])
              || (size == 2'b10 && addr[1:0] != 2'b00)
              || (mem_read && mem_write)
              || (addr[31:ADDR_WIDTH+2] != '0);

    assign do_store = accept && mem_write && !bad && !rst;
    assign mem_addr = (state_q == CLEAR) ? clr_cnt : addr[ADDR_WIDTH+1:2];

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (clr_cnt == '1) state_d = READY;
            default: state_d = READY;
        endcase
    end

    // Store data is replicated so each lane sees its own byte at its own slot.
    always_comb begin
        store_word = data_in;
        lane_we    = '0;
        case (size)
            2'b00: begin
                store_word = {4{data_in[7:0]}};
                lane_we    = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                store_word = {2{data_in[15:0]}};
                lane_we    = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: lane_we = 4'b1111;
        endcase
        lane_wdata = store_word;
        if (!do_store) lane_we = '0;
        if (state_q == CLEAR) begin
            lane_we    = '1;
            lane_wdata = '0;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            data_memory_be_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
                .clk   (clk),
                .we    (lane_we[i]),
                .addr  (mem_addr),
                .wdata (lane_wdata[i]),
                .rdata (lane_rdata[i])
            );
        end
    endgenerate

    always_comb begin
        ld_byte  = lane_rdata[addr[1:0]];
        ld_half  = addr[1] ? {lane_rdata[3], lane_rdata[2]} : {lane_rdata[1], lane_rdata[0]};
        load_ext = lane_rdata;
        case (size)
            2'b00:   load_ext = load_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = load_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_ext = lane_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? CLEAR : READY;
            clr_cnt   <= '0;
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            data_out  <= '0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            if (state_q == CLEAR) clr_cnt <= clr_cnt + 1'b1;
            if (accept && is_access) begin
                rsp_valid <= 1'b1;
                if (bad)           err      <= 1'b1;
                else if (mem_read) data_out <= load_ext;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_be.sv
// Directed bench for data_memory_be: clear sweep, lane stores, load extension, errors, resets.

module tb_data_memory_be;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, mem_read, mem_write, load_unsigned;
    logic [31:0] addr, data_in, data_out;
    logic [1:0]  size;
    logic        rsp_valid, err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        rv, er;
    logic [31:0] dout;

    data_memory_be dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .size(size),
        .load_unsigned(load_unsigned), .data_in(data_in), .rsp_valid(rsp_valid),
        .data_out(data_out), .err(err)
    );

    always #5 clk = ~clk;

    // One request for one cycle; response is sampled just after the accepting edge.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [1:0] sz, input logic uns, input logic [31:0] d);
        req_valid = 1'b1; mem_read = rd; mem_write = wr; addr = a;
        size = sz; load_unsigned = uns; data_in = d;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        rv = rsp_valid; er = err; dout = data_out;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!req_ready && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if ({req_ready, rsp_valid, err} !== 3'b000) begin n_fail++;
            $display("FAIL reset_flags: got %b want 000", {req_ready, rsp_valid, err}); end
        n_cmp++; if (data_out !== 32'h0) begin n_fail++;
            $display("FAIL reset_dout: got %h want 00000000", data_out); end
        wait_ready(cyc);
        n_cmp++; if (cyc != 1024) begin n_fail++;
            $display("FAIL clear_len: got %0d want 1024", cyc); end
        do_req(1, 0, 32'h0FFC, 2'b10, 0, 0);
        n_cmp++; if ({rv, er, dout} !== {2'b10, 32'h0}) begin n_fail++;
            $display("FAIL clear_load_ffc: got rv=%b err=%b %h want 1 0 00000000", rv, er, dout); end
    endtask

    task automatic test_byte_lanes();
        do_req(0, 1, 32'h10, 2'b10, 0, 32'h11223344);
        n_cmp++; if ({rv, er, dout} !== {2'b10, 32'h0}) begin n_fail++;
            $display("FAIL store_ack: got rv=%b err=%b %h want 1 0 00000000", rv, er, dout); end
        do_req(0, 1, 32'h11, 2'b00, 0, 32'h000000AA);
        do_req(0, 1, 32'h12, 2'b01, 0, 32'h0000BEEF);
        do_req(1, 0, 32'h10, 2'b10, 0, 0);
        n_cmp++; if ({rv, er, dout} !== {2'b10, 32'hBEEFAA44}) begin n_fail++;
            $display("FAIL lanes_word: got rv=%b err=%b %h want 1 0 beefaa44", rv, er, dout); end
    endtask

    task automatic test_load_ext();
        do_req(0, 1, 32'h20, 2'b10, 0, 32'h80FF7F01);
        do_req(1, 0, 32'h21, 2'b00, 0, 0);
        n_cmp++; if (dout !== 32'h0000007F) begin n_fail++;
            $display("FAIL lb_21: got %h want 0000007f", dout); end
        do_req(1, 0, 32'h22, 2'b00, 0, 0);
        n_cmp++; if (dout !== 32'hFFFFFFFF) begin n_fail++;
            $display("FAIL lb_22: got %h want ffffffff", dout); end
        do_req(1, 0, 32'h22, 2'b00, 1, 0);
        n_cmp++; if (dout !== 32'h000000FF) begin n_fail++;
            $display("FAIL lbu_22: got %h want 000000ff", dout); end
        do_req(1, 0, 32'h22, 2'b01, 0, 0);
        n_cmp++; if (dout !== 32'hFFFF80FF) begin n_fail++;
            $display("FAIL lh_22: got %h want ffff80ff", dout); end
        do_req(1, 0, 32'h22, 2'b01, 1, 0);
        n_cmp++; if (dout !== 32'h000080FF) begin n_fail++;
            $display("FAIL lhu_22: got %h want 000080ff", dout); end
        do_req(1, 0, 32'h20, 2'b01, 0, 0);
        n_cmp++; if (dout !== 32'h00007F01) begin n_fail++;
            $display("FAIL lh_20: got %h want 00007f01", dout); end
        do_req(1, 0, 32'h23, 2'b00, 1, 0);
        n_cmp++; if (dout !== 32'h00000080) begin n_fail++;
            $display("FAIL lbu_23: got %h want 00000080", dout); end
    endtask

    task automatic test_errors();
        do_req(0, 1, 32'h04, 2'b10, 0, 32'h55667788);
        do_req(1, 0, 32'h23, 2'b00, 1, 0);
        do_req(0, 1, 32'h06, 2'b10, 0, 32'hDEADBEEF);
        n_cmp++; if ({rv, er, dout} !== {2'b11, 32'h00000080}) begin n_fail++;
            $display("FAIL mis_word_st: got rv=%b err=%b %h want 1 1 00000080", rv, er, dout); end
        do_req(0, 1, 32'h05, 2'b01, 0, 32'h1234);
        n_cmp++; if ({rv, er} !== 2'b11) begin n_fail++;
            $display("FAIL mis_half_st: got %b want 11", {rv, er}); end
        do_req(1, 0, 32'h04, 2'b11, 0, 0);
        n_cmp++; if ({rv, er} !== 2'b11) begin n_fail++;
            $display("FAIL size_11: got %b want 11", {rv, er}); end
        do_req(1, 1, 32'h04, 2'b10, 0, 32'h0);
        n_cmp++; if ({rv, er} !== 2'b11) begin n_fail++;
            $display("FAIL rd_and_wr: got %b want 11", {rv, er}); end
        do_req(1, 0, 32'h00001000, 2'b10, 0, 0);
        n_cmp++; if ({rv, er, dout} !== {2'b11, 32'h00000080}) begin n_fail++;
            $display("FAIL range_ld: got rv=%b err=%b %h want 1 1 00000080", rv, er, dout); end
        do_req(0, 0, 32'h04, 2'b10, 0, 0);
        n_cmp++; if ({rv, er} !== 2'b00) begin n_fail++;
            $display("FAIL noop: got %b want 00", {rv, er}); end
        do_req(1, 0, 32'h04, 2'b10, 0, 0);
        n_cmp++; if ({rv, er, dout} !== {2'b10, 32'h55667788}) begin n_fail++;
            $display("FAIL word_04_kept: got rv=%b err=%b %h want 1 0 55667788", rv, er, dout); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; addr = 32'h30;
        size = 2'b10; load_unsigned = 1'b0; data_in = 32'hCAFEF00D;
        @(posedge clk); #1;
        n_cmp++; if ({rsp_valid, err, data_out} !== {2'b10, 32'h55667788}) begin n_fail++;
            $display("FAIL b2b_ack: got rv=%b err=%b %h want 1 0 55667788", rsp_valid, err, data_out); end
        mem_read = 1'b1; mem_write = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read = 1'b0;
        n_cmp++; if ({rsp_valid, err, data_out} !== {2'b10, 32'hCAFEF00D}) begin n_fail++;
            $display("FAIL b2b_load: got rv=%b err=%b %h want 1 0 cafef00d", rsp_valid, err, data_out); end
        @(posedge clk); #1;
        n_cmp++; if ({rsp_valid, err} !== 2'b00) begin n_fail++;
            $display("FAIL idle_after: got %b want 00", {rsp_valid, err}); end
    endtask

    task automatic test_rst_inflight();
        int cyc;
        req_valid = 1'b1; mem_read = 1'b1; addr = 32'h30; size = 2'b10;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; mem_read = 1'b0;
        n_cmp++; if ({rsp_valid, data_out} !== {1'b0, 32'h0}) begin n_fail++;
            $display("FAIL rst_inflight: got rv=%b %h want 0 00000000", rsp_valid, data_out); end
        // Requests during the clear sweep must be ignored.
        req_valid = 1'b1; mem_read = 1'b1; addr = 32'h30;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL clear_ignore: got %b want 0", rsp_valid); end
        wait_ready(cyc);
        n_cmp++; if (cyc != 1023) begin n_fail++;
            $display("FAIL clear_len2: got %0d want 1023", cyc); end
    endtask

    task automatic test_reset_mid_clear();
        int cyc;
        do_req(0, 1, 32'h40, 2'b10, 0, 32'h0BADF00D);
        do_req(0, 1, 32'h0FFC, 2'b10, 0, 32'h12345678);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (500) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ready(cyc);
        n_cmp++; if (cyc != 1024) begin n_fail++;
            $display("FAIL restart_len: got %0d want 1024", cyc); end
        do_req(1, 0, 32'h40, 2'b10, 0, 0);
        n_cmp++; if ({rv, er, dout} !== {2'b10, 32'h0}) begin n_fail++;
            $display("FAIL restart_w40: got rv=%b err=%b %h want 1 0 00000000", rv, er, dout); end
        do_req(1, 0, 32'h0FFC, 2'b10, 0, 0);
        n_cmp++; if (dout !== 32'h0) begin n_fail++;
            $display("FAIL restart_wffc: got %h want 00000000", dout); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        addr = '0; size = 2'b10; load_unsigned = 1'b0; data_in = '0;
        @(posedge clk); #1;
        test_reset();
        test_byte_lanes();
        test_load_ext();
        test_errors();
        test_back_to_back();
        test_rst_inflight();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/data_memory_be.md
DATA_MEMORY_BE -- requirements
Module: data_memory_be

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning word-address bits; depth = 2**ADDR_WIDTH 32-bit words.
REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1, meaning 1 = zero every word after reset, 0 = skip the clear.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present this cycle.
REQ-006 SHALL have port req_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port mem_read  input  1  request is a load.
REQ-008 SHALL have port mem_write  input  1  request is a store.
REQ-009 SHALL have port addr  input  32  byte address; word index = addr[ADDR_WIDTH+1:2].
REQ-010 SHALL have port size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-011 SHALL have port load_unsigned  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-012 SHALL have port data_in  input  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-013 SHALL have port rsp_valid  output  1  one-cycle pulse: load data or error status valid.
REQ-014 SHALL have port data_out  output  32  extended load data, held until the next rsp_valid.
REQ-015 SHALL have port err  output  1  with rsp_valid, request rejected; memory unchanged.

Function
REQ-016 SHALL accept a request only on a cycle where req_valid and req_ready are both 1.
REQ-017 SHALL implement an FSM with states CLEAR and READY; req_ready = 1 only in READY.
REQ-018 SHALL in CLEAR write 0 to word clr_cnt each cycle, clr_cnt counting 0 to depth-1, then enter READY.
REQ-019 SHALL enter READY directly after reset when CLEAR_ON_RESET = 0.
REQ-020 SHALL, for an accepted store, write only the selected byte lanes at the next edge: byte lane addr[1:0]; halfword lanes {addr[1],0} and {addr[1],1}; word all four lanes.
REQ-021 SHALL, for an accepted load, register the data from the array: data_out and rsp_valid = 1 one cycle after acceptance (latency 1).
REQ-022 SHALL extract the load byte or halfword at its byte offset and extend it to 32 bits per load_unsigned; word loads pass through unchanged.
REQ-023 SHALL raise rsp_valid = 1 with err = 1 one cycle after acceptance, without modifying memory or data_out, on any of: halfword with addr[0] = 1; word with addr[1:0] != 0; size = 11; mem_read and mem_write both 1; addr[31:ADDR_WIDTH+2] != 0.
REQ-024 SHALL pulse rsp_valid with err = 0 one cycle after a legal accepted store (store acknowledge); data_out holds its value.
REQ-025 SHALL treat an accepted request with mem_read = mem_write = 0 as a no-op: no rsp_valid.
REQ-026 SHALL make a store visible to a load accepted in the following cycle (back-to-back store then load returns the new data).
REQ-027 SHALL drive err = 0 whenever rsp_valid = 0.
REQ-028 SHALL ignore req_valid while in CLEAR: no response and no memory access.

Reset
REQ-029 SHALL, when rst = 1 at a rising edge, set state to CLEAR (or READY if CLEAR_ON_RESET = 0), clr_cnt = 0, rsp_valid = 0, err = 0 and data_out = 0, overriding any request that cycle.
REQ-030 SHALL, when rst is asserted mid-clear, restart the clear from word 0.
REQ-031 SHALL, when rst is asserted with a load in flight, drop that response: no rsp_valid the next cycle.

Verification
REQ-032 SHALL cover reset then clear: rst 1 cycle, depth 1024 -> req_ready = 0 for exactly 1024 cycles, then 1; a word load from 0x0FFC returns 0x00000000.
REQ-033 SHALL cover byte-lane stores: word store 0x11223344 @0x10, byte store 0xAA @0x11, halfword store 0xBEEF @0x12 -> word load @0x10 returns 0xBEEFAA44.
REQ-034 SHALL cover load extension: word 0x80FF7F01 @0x20 -> byte load @0x21 signed = 0x0000007F; byte load @0x22 signed = 0xFFFFFFFF, unsigned = 0x000000FF; halfword load @0x22 signed = 0xFFFF80FF.
REQ-035 SHALL cover misalignment and range: word store @0x06 -> rsp_valid = 1, err = 1, word @0x04 unchanged; load @0x00001000 with ADDR_WIDTH = 10 -> err = 1.
REQ-036 SHALL cover back-to-back store then load on consecutive cycles to @0x30 with 0xCAFEF00D -> rsp_valid with err = 0 on the store acknowledge, then data_out = 0xCAFEF00D exactly one cycle after the load is accepted.
REQ-037 SHALL cover rst asserted at clear cycle 500 -> clear restarts at word 0; req_ready = 0 for 1024 further cycles.
